// File: rtl/lkdestport_hold_decoder_pkg.sv
// Shared definitions for the look-ahead destination-port hold decoder:
// width helper, default port-index width, one-hot decode and route legality.
package lkdestport_hold_decoder_pkg;

    // Ceiling log2 with a floor of 1 so single-entry structures still get a bit.
    function automatic int log2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    // Default router port count and the matching port-index width.
    localparam int P_DEFAULT = 5;
    localparam int Pw        = log2(P_DEFAULT);

    // Turns a binary port index into a one-hot request vector.
    // Callers keep only the low P bits they need.
    function automatic logic [31:0] port_to_onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

    // A route is legal when it names an existing port and, unless the
    // router allows U-turns, does not point back at the port it came from.
    function automatic logic route_is_legal(
        input logic [31:0] port,
        input int          p,
        input int          sw_loc,
        input int          self_loop_en
    );
        logic legal;
        legal = (port < 32'(p));
        if ((self_loop_en == 0) && (port == 32'(sw_loc))) begin
            legal = 1'b0;
        end
        return legal;
    endfunction

endpackage

// File: rtl/lkdestport_hold_decoder_lkroute_fifo.sv
// Single-VC circular store of look-ahead routes, one entry per buffered
// packet. Depth need not be a power of two, so pointers wrap explicitly.
module lkroute_fifo
    import lkdestport_hold_decoder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = 3,
    localparam int CW   = log2(DEPTH + 1),
    localparam int IW   = log2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] front,
    output logic [CW-1:0] count,
    output logic          err_overflow,
    output logic          err_underflow
);

    localparam logic [CW-1:0] PTR_ONE = CW'(1);
    localparam logic [CW-1:0] PTR_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          pop_ok;
    logic          push_ok;

    // Advance a pointer by one slot, wrapping at the configured depth.
    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == PTR_LAST) ? '0 : (p + PTR_ONE);
    endfunction

    // Decide which requests take effect; a pop from empty never bypasses a
    // same-cycle push, while a pop from full frees the slot for the push.
    always_comb begin
        pop_ok        = pop && (count_q != '0);
        push_ok       = push && ((count_q != CNT_FULL) || pop_ok);
        err_overflow  = push && !push_ok;
        err_underflow = pop && (count_q == '0);
    end

    // Next pointers, occupancy and storage contents.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_ok) begin
            wr_ptr_d                 = ptr_inc(wr_ptr_q);
            mem_d[wr_ptr_q[IW-1:0]]  = din;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state is cleared by reset at any time, even mid-packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Route storage is never reset; the count alone says what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign front = mem_q[rd_ptr_q[IW-1:0]];
    assign count = count_q;

endmodule

// File: rtl/lkdestport_hold_decoder.sv
// Per-input-port holder of look-ahead routes. Head flits deposit their
// precomputed destination port; each VC's oldest packet is presented to the
// allocators as a one-hot port request until its tail flit departs.
module lkdestport_hold_decoder
    import lkdestport_hold_decoder_pkg::*;
#(
    parameter int V            = 4,
    parameter int P            = 5,
    parameter int MAX_PCK      = 2,
    parameter int SW_LOC       = 0,
    parameter int SELF_LOOP_EN = 0,
    localparam int PW          = log2(P),
    localparam int CW          = log2(MAX_PCK + 1)
) (
    input  logic           reset,
    input  logic           clk,
    input  logic           wr_en,
    input  logic [V-1:0]   wr_vc,
    input  logic           wr_hdr,
    input  logic [PW-1:0]  wr_destport,
    input  logic           rd_en,
    input  logic [V-1:0]   rd_vc,
    input  logic           rd_tail,
    output logic [V-1:0]   route_valid,
    output logic [V*P-1:0] route_onehot,
    output logic           err_overflow,
    output logic           err_underflow,
    output logic           err_illegal
);

    logic          route_legal;
    logic          hdr_write;
    logic          tail_read;
    logic [V-1:0]  push_req;
    logic [V-1:0]  pop_req;
    logic [V-1:0]  ovf_pulse;
    logic [V-1:0]  udf_pulse;
    logic          err_overflow_q, err_overflow_d;
    logic          err_underflow_q, err_underflow_d;
    logic          err_illegal_q, err_illegal_d;

    // Qualify head writes and tail reads, and screen the incoming route.
    always_comb begin
        hdr_write   = wr_en && wr_hdr;
        tail_read   = rd_en && rd_tail;
        route_legal = route_is_legal(32'(wr_destport), P, SW_LOC, SELF_LOOP_EN);
        push_req    = (hdr_write && route_legal) ? wr_vc : '0;
        pop_req     = tail_read ? rd_vc : '0;
    end

    // One route FIFO per VC; outputs decode straight from registered state.
    for (genvar v = 0; v < V; v++) begin : g_vc
        logic [PW-1:0] front;
        logic [CW-1:0] count;

        lkroute_fifo #(
            .DEPTH (MAX_PCK),
            .DW    (PW)
        ) u_fifo (
            .clk           (clk),
            .reset         (reset),
            .push          (push_req[v]),
            .pop           (pop_req[v]),
            .din           (wr_destport),
            .front         (front),
            .count         (count),
            .err_overflow  (ovf_pulse[v]),
            .err_underflow (udf_pulse[v])
        );

        assign route_valid[v]       = (count != '0);
        assign route_onehot[v*P +: P] = (count != '0) ? P'(port_to_onehot(32'(front))) : '0;
    end

    // Error flags collect any per-VC event and hold it until reset.
    always_comb begin
        err_overflow_d  = err_overflow_q  || (|ovf_pulse);
        err_underflow_d = err_underflow_q || (|udf_pulse);
        err_illegal_d   = err_illegal_q   || (hdr_write && !route_legal);
    end

    // Sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            err_illegal_q   <= 1'b0;
        end else begin
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
            err_illegal_q   <= err_illegal_d;
        end
    end

    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
    assign err_illegal   = err_illegal_q;

endmodule

// File: tb/tb_lkdestport_hold_decoder.sv
// Self-checking bench for lkdestport_hold_decoder: directed scenarios plus a
// randomized run compared against a queue-per-VC reference model.
module tb_lkdestport_hold_decoder;

    localparam int NV  = 4;
    localparam int NP  = 5;
    localparam int MAXP = 2;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_vc;
    logic        wr_hdr;
    logic [2:0]  wr_destport;
    logic        rd_en;
    logic [3:0]  rd_vc;
    logic        rd_tail;
    logic [3:0]  route_valid;
    logic [19:0] route_onehot;
    logic        err_overflow;
    logic        err_underflow;
    logic        err_illegal;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue of pending routes per VC plus sticky flags.
    int   mq [NV][$];
    logic m_ovf;
    logic m_udf;
    logic m_ill;

    lkdestport_hold_decoder #(
        .V            (NV),
        .P            (NP),
        .MAX_PCK      (MAXP),
        .SW_LOC       (0),
        .SELF_LOOP_EN (0)
    ) dut (
        .reset         (reset),
        .clk           (clk),
        .wr_en         (wr_en),
        .wr_vc         (wr_vc),
        .wr_hdr        (wr_hdr),
        .wr_destport   (wr_destport),
        .rd_en         (rd_en),
        .rd_vc         (rd_vc),
        .rd_tail       (rd_tail),
        .route_valid   (route_valid),
        .route_onehot  (route_onehot),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_illegal   (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus must keep VC selects one-hot whenever they are enabled.
    always @(negedge clk) begin
        if (wr_en) assert ($onehot(wr_vc)) else $error("[TB] wr_vc not one-hot: %b", wr_vc);
        if (rd_en) assert ($onehot(rd_vc)) else $error("[TB] rd_vc not one-hot: %b", rd_vc);
    end

    function automatic int vc_index(input logic [3:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < NV; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NV; i++) mq[i].delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_ill = 1'b0;
    endfunction

    // Applies one clock's worth of activity: tail pops first, then head pushes,
    // so a full VC can accept a push in the cycle its tail leaves, while an
    // empty VC's pop never consumes the same-cycle push.
    function automatic void model_apply(input logic wen, input logic [3:0] wvc, input logic whdr,
                                        input logic [2:0] wdp, input logic ren, input logic [3:0] rvc,
                                        input logic rtail);
        int wv;
        int rv;
        wv = vc_index(wvc);
        rv = vc_index(rvc);
        if (ren && rtail) begin
            if (mq[rv].size() == 0) m_udf = 1'b1;
            else void'(mq[rv].pop_front());
        end
        if (wen && whdr) begin
            if (int'(wdp) >= NP || int'(wdp) == 0) m_ill = 1'b1;
            else if (mq[wv].size() >= MAXP) m_ovf = 1'b1;
            else mq[wv].push_back(int'(wdp));
        end
    endfunction

    function automatic logic [3:0] exp_valid();
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NV; i++) r[i] = (mq[i].size() != 0);
        return r;
    endfunction

    function automatic logic [19:0] exp_onehot();
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < NV; i++) begin
            if (mq[i].size() != 0) r[i*NP + mq[i][0]] = 1'b1;
        end
        return r;
    endfunction

    // Drives one cycle of inputs, advances the model on the edge and returns
    // the bench to idle one time unit later, ready for sampling.
    task automatic applyStimulus(input logic wen, input logic [3:0] wvc, input logic whdr,
                                 input logic [2:0] wdp, input logic ren, input logic [3:0] rvc,
                                 input logic rtail);
        wr_en       = wen;
        wr_vc       = wvc;
        wr_hdr      = whdr;
        wr_destport = wdp;
        rd_en       = ren;
        rd_vc       = rvc;
        rd_tail     = rtail;
        @(posedge clk);
        model_apply(wen, wvc, whdr, wdp, ren, rvc, rtail);
        #1;
        wr_en   = 1'b0;
        wr_vc   = '0;
        wr_hdr  = 1'b0;
        rd_en   = 1'b0;
        rd_vc   = '0;
        rd_tail = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (route_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b expected 0000", route_valid);
        end
        checks++;
        if (route_onehot !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset_onehot: got %h expected 00000", route_onehot);
        end
        checks++;
        if ({err_overflow, err_underflow, err_illegal} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_errs: got %b expected 000", {err_overflow, err_underflow, err_illegal});
        end
    endtask

    task automatic test_single_packet();
        do_reset();
        applyStimulus(1'b1, 4'b0010, 1'b1, 3'd3, 1'b0, 4'b0000, 1'b0);
        checks++;
        if (route_valid !== 4'b0010 || route_onehot[9:5] !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL single_head: valid %b slice %b expected 0010 01000", route_valid, route_onehot[9:5]);
        end
        applyStimulus(1'b1, 4'b0010, 1'b0, 3'd7, 1'b1, 4'b0010, 1'b0);
        checks++;
        if (route_valid !== 4'b0010 || route_onehot[9:5] !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL single_body: valid %b slice %b expected 0010 01000", route_valid, route_onehot[9:5]);
        end
        applyStimulus(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 4'b0010, 1'b1);
        checks++;
        if (route_valid !== 4'b0000 || route_onehot !== 20'h0 || err_underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_tail: valid %b onehot %h udf %b expected 0000 00000 0",
                     route_valid, route_onehot, err_underflow);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        applyStimulus(1'b1, 4'b0001, 1'b1, 3'd2, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0001, 1'b1, 3'd4, 1'b0, 4'b0000, 1'b0);
        checks++;
        if (route_valid !== 4'b0001 || route_onehot[4:0] !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL b2b_first: valid %b slice %b expected 0001 00100", route_valid, route_onehot[4:0]);
        end
        applyStimulus(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 4'b0001, 1'b1);
        checks++;
        if (route_valid !== 4'b0001 || route_onehot[4:0] !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL b2b_second: valid %b slice %b expected 0001 10000", route_valid, route_onehot[4:0]);
        end
        applyStimulus(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 4'b0001, 1'b1);
        checks++;
        if (route_valid !== 4'b0000 || route_onehot !== 20'h0) begin
            errors++;
            $display("[TB] FAIL b2b_empty: valid %b onehot %h expected 0000 00000", route_valid, route_onehot);
        end
    endtask

    task automatic test_full();
        do_reset();
        applyStimulus(1'b1, 4'b0100, 1'b1, 3'd1, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b1, 3'd3, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b1, 3'd2, 1'b0, 4'b0000, 1'b0);
        checks++;
        if (err_overflow !== 1'b1 || route_onehot[14:10] !== 5'b00010) begin
            errors++;
            $display("[TB] FAIL full_overflow: ovf %b slice %b expected 1 00010", err_overflow, route_onehot[14:10]);
        end
        do_reset();
        applyStimulus(1'b1, 4'b0100, 1'b1, 3'd1, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b1, 3'd3, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b1, 3'd2, 1'b1, 4'b0100, 1'b1);
        checks++;
        if (err_overflow !== 1'b0 || route_onehot[14:10] !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL full_pushpop: ovf %b slice %b expected 0 01000", err_overflow, route_onehot[14:10]);
        end
        applyStimulus(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 4'b0100, 1'b1);
        checks++;
        if (route_valid !== 4'b0100 || route_onehot[14:10] !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL full_third: valid %b slice %b expected 0100 00100", route_valid, route_onehot[14:10]);
        end
        applyStimulus(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 4'b0100, 1'b1);
        checks++;
        if (route_valid !== 4'b0000 || err_underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_drain: valid %b udf %b expected 0000 0", route_valid, err_underflow);
        end
    endtask

    task automatic test_illegal_underflow();
        do_reset();
        applyStimulus(1'b1, 4'b0001, 1'b1, 3'd0, 1'b0, 4'b0000, 1'b0);
        checks++;
        if (err_illegal !== 1'b1 || route_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL illegal_selfloop: ill %b valid %b expected 1 0000", err_illegal, route_valid);
        end
        do_reset();
        applyStimulus(1'b1, 4'b0001, 1'b1, 3'd6, 1'b0, 4'b0000, 1'b0);
        checks++;
        if (err_illegal !== 1'b1 || route_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL illegal_range: ill %b valid %b expected 1 0000", err_illegal, route_valid);
        end
        do_reset();
        applyStimulus(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 4'b1000, 1'b1);
        checks++;
        if (err_underflow !== 1'b1 || err_illegal !== 1'b0 || route_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL underflow: udf %b ill %b valid %b expected 1 0 0000",
                     err_underflow, err_illegal, route_valid);
        end
        do_reset();
        applyStimulus(1'b1, 4'b1000, 1'b1, 3'd4, 1'b1, 4'b1000, 1'b1);
        checks++;
        if (err_underflow !== 1'b1 || route_valid !== 4'b1000 || route_onehot[19:15] !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL empty_pushpop: udf %b valid %b slice %b expected 1 1000 10000",
                     err_underflow, route_valid, route_onehot[19:15]);
        end
    endtask

    task automatic test_single_flit_and_reset();
        int valid_cycles;
        do_reset();
        valid_cycles = 0;
        applyStimulus(1'b1, 4'b0010, 1'b1, 3'd1, 1'b0, 4'b0000, 1'b0);
        if (route_valid[1]) valid_cycles++;
        idle();
        if (route_valid[1]) valid_cycles++;
        applyStimulus(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 4'b0010, 1'b1);
        if (route_valid[1]) valid_cycles++;
        idle();
        if (route_valid[1]) valid_cycles++;
        checks++;
        if (valid_cycles != 2) begin
            errors++;
            $display("[TB] FAIL single_flit_window: got %0d cycles expected 2", valid_cycles);
        end
        applyStimulus(1'b1, 4'b0001, 1'b1, 3'd2, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0001, 1'b1, 3'd6, 1'b0, 4'b0000, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (route_valid !== 4'b0000 || route_onehot !== 20'h0 || err_illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: valid %b onehot %h ill %b expected 0000 00000 0",
                     route_valid, route_onehot, err_illegal);
        end
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic       wen;
        logic [3:0] wvc;
        logic       whdr;
        logic [2:0] wdp;
        logic       ren;
        logic [3:0] rvc;
        logic       rtail;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n % 80 == 79) do_reset();
            wen   = 1'($urandom_range(0, 1));
            wvc   = 4'b0001 << $urandom_range(0, 3);
            whdr  = ($urandom_range(0, 3) != 0);
            wdp   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
            ren   = 1'($urandom_range(0, 1));
            rvc   = 4'b0001 << $urandom_range(0, 3);
            rtail = ($urandom_range(0, 2) != 0);
            applyStimulus(wen, wvc, whdr, wdp, ren, rvc, rtail);
            checks++;
            if (route_valid !== exp_valid() || route_onehot !== exp_onehot()) begin
                errors++;
                $display("[TB] FAIL random_route cycle %0d: valid %b onehot %h expected %b %h",
                         n, route_valid, route_onehot, exp_valid(), exp_onehot());
            end
            checks++;
            if ({err_overflow, err_underflow, err_illegal} !== {m_ovf, m_udf, m_ill}) begin
                errors++;
                $display("[TB] FAIL random_errs cycle %0d: got %b expected %b",
                         n, {err_overflow, err_underflow, err_illegal}, {m_ovf, m_udf, m_ill});
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        wr_en       = 1'b0;
        wr_vc       = '0;
        wr_hdr      = 1'b0;
        wr_destport = '0;
        rd_en       = 1'b0;
        rd_vc       = '0;
        rd_tail     = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_full();
        test_illegal_underflow();
        test_single_flit_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lkdestport_hold_decoder.md
# lkdestport_hold_decoder

Per-input-port store for look-ahead routing results. Each head flit carries the destination port its router computed one hop upstream. This block captures that port number when the head flit is written into a VC buffer, keeps one entry per buffered packet, and presents each VC's front entry as a one-hot output-port request. An entry is released when that packet's tail flit leaves the buffer. The block sits between the input-port flit write path and the VC/switch allocators.

## Interface
- `V`, 4: virtual channels per input port.
- `P`, 5: router ports. `Pw = log2(P)`.
- `MAX_PCK`, 2: maximum packets buffered per VC, which sets the route FIFO depth per VC. Must be ≥1.
- `SW_LOC`, 0: index of the input port this instance serves.
- `SELF_LOOP_EN`, 0: if 0, a route equal to `SW_LOC` is illegal.
- `reset` in 1: asynchronous, active-high.
- `clk` in 1: single clock, rising edge.
- `wr_en` in 1: a flit is written into the buffer this cycle.
- `wr_vc` in V: one-hot VC of the written flit.
- `wr_hdr` in 1: the written flit is a head flit.
- `wr_destport` in Pw: binary look-ahead destination port of the head flit.
- `rd_en` in 1: a flit leaves the buffer this cycle.
- `rd_vc` in V: one-hot VC of the departing flit.
- `rd_tail` in 1: the departing flit is a tail flit (a single-flit packet sets head and tail).
- `route_valid` out V: the VC has at least one stored route.
- `route_onehot` out V*P: front route per VC, one-hot. Slice `[(v+1)*P-1 : v*P]` belongs to VC v.
- `err_overflow` out 1: sticky error flag.
- `err_underflow` out 1: sticky error flag.
- `err_illegal` out 1: sticky error flag.

## Operation
- **Push:** `wr_en & wr_hdr` with `wr_vc[v]` appends `wr_destport` to FIFO v, provided the route is legal and FIFO v has space.
  - Illegal route: `wr_destport ≥ P`, or `SELF_LOOP_EN==0` and `wr_destport==SW_LOC`. The entry is not pushed and `err_illegal` sets.
- **Pop:** `rd_en & rd_tail` with `rd_vc[v]` removes the front entry of FIFO v.
  - Body flits (`rd_tail=0`) leave all state unchanged.
- **Per-VC state:** read pointer, write pointer and a count, each `log2(MAX_PCK+1)` bits wide. Pointers wrap at `MAX_PCK` (modulo `MAX_PCK`, not a power of two).
- **Outputs:**
  - `route_valid[v] = (count_v != 0)`.
  - `route_onehot` for VC v is the decode of the front entry; all zeros when count_v is 0.
  - Outputs are decoded combinationally from registered state.
- **Boundary behaviour:**
  - Full (`count==MAX_PCK`), push with no pop on the same VC: push dropped, `err_overflow` sets.
  - Full, push and pop on the same VC in the same cycle: both take effect, count stays `MAX_PCK`.
  - Empty, pop: ignored, `err_underflow` sets.
  - Empty, push and pop on the same VC in the same cycle: the pop is an underflow (no bypass); the push succeeds and count becomes 1.
  - Push on VC a and pop on VC b in the same cycle: both proceed independently.
  - `wr_vc` or `rd_vc` not one-hot while the corresponding enable is high: behaviour undefined. The verification bench flags this with assertions.
- **Error flags:** sticky until reset.
- **Reset:** clears all pointers, counts and error flags at any time, including mid-packet. The FIFO storage itself is not reset.

## Timing
- Reset values:
  - `route_valid` = 0.
  - `route_onehot` = 0.
  - All `err_*` = 0.
- Push-to-visible latency is 1 cycle: head written at edge N, `route_valid` and `route_onehot` update after edge N.
- Pop-to-next-entry latency is 1 cycle: the next packet's route appears after the edge that pops the tail.
- No combinational path exists from `wr_*` or `rd_*` to any output.

## Structure
- Shared package holds:
  - the `log2` function,
  - `Pw`,
  - the port-index-to-one-hot decode function,
  - the route-legality function (parameterised by `SW_LOC` and `SELF_LOOP_EN`).
- One sub-module, `lkroute_fifo`: a single-VC circular FIFO of `MAX_PCK` × `Pw` bits with push, pop, count and front output.
  - The top level instantiates V copies in a generate loop.
  - The top level does the one-hot decode and ORs the per-VC error pulses into the sticky flags.

## Test plan
- **Single packet:** reset, then head on VC1 with destport 3, body, tail.
  - After the head: `route_valid=4'b0010`, VC1 slice `= 5'b01000`.
  - Cleared 1 cycle after the tail pops.
- **Back-to-back packets:** two packets on VC0 with routes 2 then 4, written before either pops.
  - Front shows `5'b00100`.
  - After the first tail pops: `5'b10000`.
  - After the second tail pops: invalid.
- **Full:** `MAX_PCK=2`, fill VC2, then a third head alone produces `err_overflow=1`.
  - Repeat with a simultaneous tail pop on VC2: no error, count stays 2.
- **Illegal and underflow:**
  - Head with destport 0 (= `SW_LOC`): not stored, `err_illegal=1`.
  - Head with destport 6: not stored, `err_illegal=1`.
  - Tail pop on an empty VC3: `err_underflow=1`.
- **Single-flit packets and mid-packet reset:**
  - Head and tail single-flit packet on VC1 route 1, popped 2 cycles later: valid for exactly 2 cycles.
  - Assert reset while VC0 holds an entry: all outputs go to 0 asynchronously.
